// File: rtl/md_pkg.sv
// Shared MULT_DIV definitions: op codes, issue-controller states and default latencies.
// Imported by the issue controller so its occupancy tracking matches the unit's real timing.
package md_pkg;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MSUB  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_state_e;

  function automatic logic md_op_legal(input logic [2:0] op);
    return op <= MD_MSUB;
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// EX/D-stage request signals and MULT_DIV control outputs of the issue controller.
// The master side is the pipeline; the slave side is md_issue_ctrl.
interface md_issue_ctrl_if;

  logic       ex_md_valid;
  logic [2:0] ex_md_op;
  logic       ex_mt_valid;
  logic       ex_mt_hilo;
  logic       ex_flush;
  logic       d_md_use;

  logic       md_start;
  logic [2:0] md_op;
  logic       md_we;
  logic       md_hilo;
  logic       md_busy;
  logic       md_stall;
  logic       md_err;

  modport master (
    output ex_md_valid, ex_md_op, ex_mt_valid, ex_mt_hilo, ex_flush, d_md_use,
    input  md_start, md_op, md_we, md_hilo, md_busy, md_stall, md_err
  );

  modport slave (
    input  ex_md_valid, ex_md_op, ex_mt_valid, ex_mt_hilo, ex_flush, d_md_use,
    output md_start, md_op, md_we, md_hilo, md_busy, md_stall, md_err
  );

endinterface

// File: rtl/md_lat_counter.sv
// Loadable down-counter with zero flag; counts MULT_DIV busy cycles remaining.
module md_lat_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for MULT_DIV: drives Start/Op/We/HiLo, tracks unit occupancy
// with its own latency counter so the D-stage stall is raised in the issue cycle itself.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = md_pkg::MUL_LAT,
  parameter int DIV_LAT = md_pkg::DIV_LAT
) (
  input  logic             Clk,
  input  logic             Rst,
  md_issue_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             idle;
  logic             decode_fault;
  logic             issue;
  logic             mt_ok;
  logic             err_nx;
  logic             err_q;

  assign idle         = (state == IDLE);
  assign decode_fault = bus.ex_md_valid & bus.ex_mt_valid;

  // Requests are only accepted from a live, unflushed, idle EX stage with a sane decode.
  assign issue = Rst & bus.ex_md_valid & ~bus.ex_mt_valid & ~bus.ex_flush & idle &
                 md_op_legal(bus.ex_md_op);
  assign mt_ok = Rst & bus.ex_mt_valid & ~bus.ex_md_valid & ~bus.ex_flush & idle;

  assign err_nx = Rst & ~bus.ex_flush &
                  (decode_fault |
                   (bus.ex_md_valid & ~md_op_legal(bus.ex_md_op)) |
                   ((bus.ex_md_valid | bus.ex_mt_valid) & ~idle));

  md_lat_counter #(.W(CNT_W)) u_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // The last busy cycle is the one where cnt reads 1; cnt<=1 also covers a 1-cycle latency.
  always_comb begin
    state_nx     = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = MUL_LOAD;
    unique case (state)
      IDLE: begin
        if (issue) begin
          cnt_load = 1'b1;
          if (md_op_is_div(bus.ex_md_op)) begin
            cnt_load_val = DIV_LOAD;
            state_nx     = DIV_BUSY;
          end else begin
            cnt_load_val = MUL_LOAD;
            state_nx     = MUL_BUSY;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero || (cnt == CNT_W'(1))) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.md_start = issue;
  assign bus.md_op    = issue ? bus.ex_md_op : 3'd0;
  assign bus.md_we    = mt_ok;
  assign bus.md_hilo  = mt_ok ? bus.ex_mt_hilo : 1'b0;
  assign bus.md_busy  = ~idle;
  assign bus.md_stall = Rst & bus.d_md_use & (~idle | issue);
  assign bus.md_err   = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: directed scenarios plus random traffic, each cycle's
// expected outputs come from a cycle-count model of MULT_DIV occupancy.
module tb_md_issue_ctrl;
  import md_pkg::*;

  typedef struct {
    bit       start;
    bit [2:0] op;
    bit       we;
    bit       hilo;
    bit       busy;
    bit       stall;
    bit       err;
  } expT;

  logic Clk;
  logic Rst;
  md_issue_ctrl_if busIf ();

  md_issue_ctrl dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busIf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  expT expQ[$];
  int  totalChecks = 0;
  int  badChecks   = 0;

  // Model: the unit is free again once the cycle number reaches readyCycle.
  int  cycleNum   = 0;
  int  readyCycle = 0;
  bit  errReg     = 1'b0;

  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s at t=%0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit mdv, input bit [2:0] op,
                               input bit mtv, input bit hilo, input bit flush,
                               input bit duse);
    expT e;
    bit  live, busy, issue, mtOk, viol;
    @(posedge Clk);
    #1;
    Rst               = rst;
    busIf.ex_md_valid = mdv;
    busIf.ex_md_op    = op;
    busIf.ex_mt_valid = mtv;
    busIf.ex_mt_hilo  = hilo;
    busIf.ex_flush    = flush;
    busIf.d_md_use    = duse;

    live  = rst;
    busy  = cycleNum < readyCycle;
    issue = live && mdv && !mtv && !flush && !busy && (op <= 3'd4);
    mtOk  = live && mtv && !mdv && !flush && !busy;
    viol  = live && !flush && ((mdv && mtv) || (mdv && op > 3'd4) || ((mdv || mtv) && busy));

    e.start = issue;
    e.op    = issue ? op : 3'd0;
    e.we    = mtOk;
    e.hilo  = mtOk ? hilo : 1'b0;
    e.busy  = busy;
    e.stall = live && duse && (busy || issue);
    e.err   = errReg;
    expQ.push_back(e);

    if (!rst) begin
      readyCycle = cycleNum + 1;
      errReg     = 1'b0;
    end else begin
      errReg = viol;
      if (issue) readyCycle = cycleNum + ((op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT);
    end
    cycleNum++;
  endtask

  task automatic idleCycles(input int n, input bit duse);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 3'd0, 0, 0, 0, duse);
  endtask

  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      checkOutput("md_start", {2'b0, busIf.md_start}, {2'b0, e.start});
      checkOutput("md_op",    busIf.md_op,            e.op);
      checkOutput("md_we",    {2'b0, busIf.md_we},    {2'b0, e.we});
      checkOutput("md_hilo",  {2'b0, busIf.md_hilo},  {2'b0, e.hilo});
      checkOutput("md_busy",  {2'b0, busIf.md_busy},  {2'b0, e.busy});
      checkOutput("md_stall", {2'b0, busIf.md_stall}, {2'b0, e.stall});
      checkOutput("md_err",   {2'b0, busIf.md_err},   {2'b0, e.err});
    end
  end

  initial begin
    Rst               = 1'b0;
    busIf.ex_md_valid = 1'b0;
    busIf.ex_md_op    = 3'd0;
    busIf.ex_mt_valid = 1'b0;
    busIf.ex_mt_hilo  = 1'b0;
    busIf.ex_flush    = 1'b0;
    busIf.d_md_use    = 1'b0;
    repeat (2) @(posedge Clk);

    $display("[TB] reset with pending mult");
    applyStimulus(0, 1, 3'd0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd0, 0, 0, 0, 1);

    $display("[TB] mult with D-stage user");
    applyStimulus(1, 1, 3'd0, 0, 0, 0, 1);
    idleCycles(6, 1);

    $display("[TB] divu");
    applyStimulus(1, 1, 3'd3, 0, 0, 0, 1);
    idleCycles(11, 1);

    $display("[TB] mthi idle then during div");
    applyStimulus(1, 0, 3'd0, 1, 1, 0, 0);
    applyStimulus(1, 1, 3'd2, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 1, 1, 0, 1);
    idleCycles(10, 0);

    $display("[TB] flush and illegal op");
    applyStimulus(1, 1, 3'd2, 0, 0, 1, 0);
    applyStimulus(1, 1, 3'd6, 0, 0, 0, 0);
    idleCycles(2, 0);

    $display("[TB] decoder fault");
    applyStimulus(1, 1, 3'd1, 1, 0, 0, 1);
    idleCycles(2, 0);

    $display("[TB] reset mid-op");
    applyStimulus(1, 1, 3'd2, 0, 0, 0, 1);
    idleCycles(3, 1);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    applyStimulus(1, 1, 3'd1, 0, 0, 0, 1);
    idleCycles(6, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 9) < 4),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 2),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)));
    end
    idleCycles(12, 1);

    repeat (3) @(posedge Clk);
    if (expQ.size() != 0) begin
      badChecks++;
      $display("[TB] FAIL scoreboard_drain: got=%0d expected=0 entries left", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- EX-stage issue controller directly upstream of the MULT_DIV unit in the P6 pipeline.
- Converts decoded EX-stage mult/div/msub/mthi/mtlo instructions into the MULT_DIV Start/Op/We/HiLo controls.
- Tracks the unit's multi-cycle occupancy with its own latency counter. This lets it raise the D-stage stall in the issue cycle itself, before MULT_DIV's Busy is visible.
- Also flags protocol violations.

Parameters:
- MUL_LAT, 5, cycles from Start to HI/LO valid for mult/multu/msub (issue cycle counted as cycle 0).
- DIV_LAT, 10, same for div/divu.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-low: Rst==0 at a rising Clk edge resets the block.
- ex_md_valid  in  1  EX holds a mult/multu/div/divu/msub.
- ex_md_op  in  3  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 msub; 5..7 illegal.
- ex_mt_valid  in  1  EX holds mthi/mtlo.
- ex_mt_hilo  in  1  1 = mthi, 0 = mtlo.
- ex_flush  in  1  EX instruction is being killed this cycle.
- d_md_use  in  1  D holds mfhi/mflo/mthi/mtlo/mult/multu/div/divu/msub.
- md_start  out  1  Start to MULT_DIV (combinational).
- md_op  out  3  Op to MULT_DIV (combinational, equals ex_md_op when md_start=1, else 0).
- md_we  out  1  We to MULT_DIV (combinational).
- md_hilo  out  1  HiLo to MULT_DIV (combinational).
- md_busy  out  1  registered: unit occupied by an earlier-issued op.
- md_stall  out  1  combinational: freeze D/F stages this cycle.
- md_err  out  1  registered one-cycle pulse on protocol violation.

Behaviour:
- State register: IDLE, MUL_BUSY, DIV_BUSY. Counter cnt, 4 bits, sized to hold max(MUL_LAT,DIV_LAT)-1.
- Reset (Rst==0 at edge): state=IDLE, cnt=0, md_busy=0, md_err=0. While Rst==0, all combinational outputs are forced to 0.
- Reset mid-operation: aborts tracking immediately. The next cycle is IDLE with no stall. MULT_DIV itself is not reset by this block.
- issue = ex_md_valid & ~ex_flush & (state==IDLE) & (ex_md_op<=4).
- md_start = issue; md_op = issue ? ex_md_op : 0.
- IDLE + issue: at the edge, load cnt = LAT-1 (MUL_LAT for ops 0,1,4; DIV_LAT for ops 2,3). Go to MUL_BUSY or DIV_BUSY respectively.
- BUSY states: at each edge, cnt = cnt-1. When cnt==1, next state is IDLE and cnt becomes 0.
- md_busy = (state != IDLE).
- Timing for an op issued in cycle 0: md_busy is high in cycles 1..LAT-1, IDLE in cycle LAT, and HI/LO are valid from cycle LAT.
- md_stall = d_md_use & (md_busy | issue). D-stage md instructions are held through cycle LAT-1 and proceed in cycle LAT.
- Move-to path:
  - mt_ok = ex_mt_valid & ~ex_flush & (state==IDLE).
  - md_we = mt_ok; md_hilo = mt_ok ? ex_mt_hilo : 0.
- ex_md_valid and ex_mt_valid both 1 (decoder fault): neither is issued. md_start=0, md_we=0; md_err pulses next cycle.
- Illegal op (5..7) with ex_md_valid=1 and no flush: no start; md_err pulses next cycle.
- ex_md_valid or ex_mt_valid while busy (stall bypassed upstream): suppressed (no start/we); md_err pulses next cycle; state and cnt unaffected.
- ex_flush=1: the EX request is ignored, no error is raised, and an op already in flight continues to completion.
- md_err is a registered pulse asserted the cycle after any violation. Consecutive violations hold it high.
- Back-to-back ops: the earliest next issue is cycle LAT. A D-stage op stalled by this block reaches EX no earlier than cycle LAT+1.

Decomposition:
- Shared package md_pkg:
  - op codes MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MSUB=4;
  - state encodings;
  - MUL_LAT/DIV_LAT defaults, so MULT_DIV counters and this block stay consistent.
- One natural sub-module: md_lat_counter (loadable down-counter with zero flag). Everything else stays inline.

Test Plan:
- Reset: hold Rst=0 for 2 cycles with ex_md_valid=1, op=0 -> md_start=0, md_busy=0, md_stall=0, md_err=0. Release, then issue op=0 -> md_start=1 the same cycle.
- mult: issue op=0 in cycle 0 with d_md_use=1 throughout -> md_start=1 in cycle 0 only. md_stall=1 in cycles 0..4, md_busy=1 in cycles 1..4, both 0 in cycle 5. Bench model of MULT_DIV shows 3*-4 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4 at cycle 5.
- divu: issue op=3 with D1=7, D2=2 -> md_busy=1 in cycles 1..9, idle in cycle 10. HI=1, LO=3 visible at cycle 10.
- mthi: ex_mt_valid=1, ex_mt_hilo=1 in IDLE -> md_we=1, md_hilo=1 that cycle. A repeat attempt while DIV_BUSY -> md_we=0, md_err=1 the next cycle, cnt sequence unchanged.
- Flush and illegal: ex_md_valid=1, op=2, ex_flush=1 -> no start, md_err=0, stays IDLE. Then op=6 without flush -> no start, md_err pulse for 1 cycle.
- Reset mid-op: issue op=2, assert Rst=0 in cycle 4 -> cycle 5 shows md_busy=0, md_stall=0 with d_md_use=1. A fresh op=1 issues in cycle 5.
